// File: rtl/gpio_irq_pkg.sv
// Shared definitions for gpio_irq: register codes, bank geometry, bank-count helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpio_irq_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int BANK_W    = 16;

  // Register code occupies Addr[4:2]; Addr[1:0] selects the 16-bit bank.
  typedef enum logic [2:0] {
    REG_DATA  = 3'd0,
    REG_DIR   = 3'd1,
    REG_SET   = 3'd2,
    REG_CLR   = 3'd3,
    REG_IEN   = 3'd4,
    REG_IRISE = 3'd5,
    REG_IFALL = 3'd6,
    REG_ISTAT = 3'd7
  } reg_e;

  function automatic int num_banks(input int width);
    return (width + BANK_W - 1) / BANK_W;
  endfunction

endpackage

// File: rtl/gpio_irq_if.sv
// Register bus between address decode (master) and gpio_irq (slave).
// Latency: writes commit on the clock edge with en & wr; reads are combinational.
// Backpressure: none; one access per clock, always accepted.
interface gpio_irq_if;
  logic [4:0]  addr;    // {reg[2:0], bank[1:0]}
  logic [15:0] datawr;
  logic [15:0] datard;  // zero unless en & rd
  logic        en;
  logic        rd;
  logic        wr;

  modport master (output addr, datawr, en, rd, wr, input datard);
  modport slave  (input addr, datawr, en, rd, wr, output datard);
endinterface

// File: rtl/gpio_irq_sync.sv
// Pin input conditioning: 2-flop synchroniser, previous-value register, edge detect, post-reset qualifier.
// Latency: pin -> sync 2 edges; rise/fall valid between edge 2 and edge 3.
// Backpressure: none.
// Ports: clk, rst (async high); pin (raw pads); sync, rise, fall (per pin); qualified (edge capture allowed).
module gpio_irq_sync #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             qualified
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] prev;
  logic [1:0]       cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
      cnt  <= '0;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
      // Saturates at 3: by then prev has caught up with any pin held
      // high through reset, so the first observed rise is genuine.
      if (cnt != 2'd3)
        cnt <= cnt + 2'd1;
    end
  end

  assign rise      = sync & ~prev;
  assign fall      = ~sync & prev;
  assign qualified = (cnt == 2'd3);

endmodule

// File: rtl/gpio_irq.sv
// GPIO register file with per-pin direction, atomic set/clear and sticky edge interrupts.
// Latency: pin edge -> ISTAT 3 edges, -> ireq 4 edges; register writes 1 edge; reads combinational.
// Backpressure: none; every en & wr cycle is a committed write.
// Ports: clk, rst (async high); bus (gpio_irq_if.slave); pin (raw pads); pout, poe (pad drive); ireq.
module gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  gpio_irq_if.slave        bus,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic [WIDTH-1:0] poe,
  output logic             ireq
);

  localparam int NB = num_banks(WIDTH);
  localparam int PW = NB * BANK_W;   // width rounded up to whole banks

  reg_e             rsel;
  logic [1:0]       bank;
  logic [5:0]       sh;
  logic             we;
  logic [PW-1:0]    wfull;
  logic [PW-1:0]    bfull;
  logic [WIDTH-1:0] wd;   // write data placed at the addressed bank
  logic [WIDTH-1:0] bm;   // bit mask of the addressed bank

  logic [WIDTH-1:0] ien;
  logic [WIDTH-1:0] irise;
  logic [WIDTH-1:0] ifall;
  logic [WIDTH-1:0] istat;
  logic [WIDTH-1:0] istat_nxt;

  logic [WIDTH-1:0] sync_v;
  logic [WIDTH-1:0] rise_v;
  logic [WIDTH-1:0] fall_v;
  logic             qualified;

  gpio_irq_sync #(.WIDTH(WIDTH)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .pin       (pin),
    .sync      (sync_v),
    .rise      (rise_v),
    .fall      (fall_v),
    .qualified (qualified)
  );

  assign rsel = reg_e'(bus.addr[4:2]);
  assign bank = bus.addr[1:0];
  assign sh   = {bank, 4'b0000};
  assign we   = bus.en & bus.wr;

  // Shifting into a bank-padded vector drops banks past the bank count
  // and truncation to WIDTH drops bits above WIDTH, so such writes vanish.
  assign wfull = PW'(bus.datawr) << sh;
  assign bfull = PW'(16'hFFFF) << sh;
  assign wd    = wfull[WIDTH-1:0];
  assign bm    = bfull[WIDTH-1:0];

  // Newly detected edges take priority over a same-cycle write-1-to-clear.
  always_comb begin
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] set;
    clr       = (we && rsel == REG_ISTAT) ? wd : '0;
    set       = qualified ? ((rise_v & irise) | (fall_v & ifall)) : '0;
    istat_nxt = (istat & ~clr) | set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pout  <= '0;
      poe   <= '0;
      ien   <= '0;
      irise <= '0;
      ifall <= '0;
      istat <= '0;
      ireq  <= 1'b0;
    end else begin
      if (we) begin
        case (rsel)
          REG_DATA:  pout  <= (pout & ~bm) | wd;
          REG_DIR:   poe   <= (poe & ~bm) | wd;
          REG_SET:   pout  <= pout | wd;
          REG_CLR:   pout  <= pout & ~wd;
          REG_IEN:   ien   <= (ien & ~bm) | wd;
          REG_IRISE: irise <= (irise & ~bm) | wd;
          REG_IFALL: ifall <= (ifall & ~bm) | wd;
          default:   ;
        endcase
      end
      istat <= istat_nxt;
      // Built from the current status, so a clear or enable shows one edge later.
      ireq  <= |(istat & ien);
    end
  end

  // Read mux: select the register, then the bank slice; unimplemented banks stay 0.
  always_comb begin
    logic [PW-1:0]     rreg;
    logic [BANK_W-1:0] rbank;
    rreg = '0;
    case (rsel)
      REG_DATA:  rreg[WIDTH-1:0] = sync_v;
      REG_DIR:   rreg[WIDTH-1:0] = poe;
      REG_IEN:   rreg[WIDTH-1:0] = ien;
      REG_IRISE: rreg[WIDTH-1:0] = irise;
      REG_IFALL: rreg[WIDTH-1:0] = ifall;
      REG_ISTAT: rreg[WIDTH-1:0] = istat;
      default:   rreg = '0;
    endcase
    rbank = '0;
    for (int b = 0; b < NB; b++) begin
      if (bank == 2'(b))
        rbank = rreg[b*BANK_W +: BANK_W];
    end
    bus.datard = (bus.en && bus.rd) ? rbank : '0;
  end

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq: a 32-pin instance for function/timing and a 20-pin instance for width masking.
module tb_gpio_irq;

  logic clk;
  logic rst;

  gpio_irq_if bus_a ();
  gpio_irq_if bus_b ();

  logic [31:0] pin_a;
  logic [31:0] pout_a;
  logic [31:0] poe_a;
  logic        ireq_a;

  logic [19:0] pin_b;
  logic [19:0] pout_b;
  logic [19:0] poe_b;
  logic        ireq_b;

  int n_cmp;
  int n_bad;

  gpio_irq #(.WIDTH(32)) dut_a (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_a),
    .pin  (pin_a),
    .pout (pout_a),
    .poe  (poe_a),
    .ireq (ireq_a)
  );

  gpio_irq #(.WIDTH(20)) dut_b (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus_b),
    .pin  (pin_b),
    .pout (pout_b),
    .poe  (poe_b),
    .ireq (ireq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] ra(input int r, input int b);
    return 5'(r * 4 + b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a write during the low phase; returns 1 ns after the committing edge.
  task automatic bus_write(input bit b, input logic [4:0] a, input logic [15:0] d);
    @(negedge clk);
    if (b) begin
      bus_b.addr = a; bus_b.datawr = d; bus_b.en = 1'b1; bus_b.wr = 1'b1;
    end else begin
      bus_a.addr = a; bus_a.datawr = d; bus_a.en = 1'b1; bus_a.wr = 1'b1;
    end
    @(posedge clk);
    #1;
    bus_a.en = 1'b0; bus_a.wr = 1'b0;
    bus_b.en = 1'b0; bus_b.wr = 1'b0;
  endtask

  task automatic bus_read(input bit b, input logic [4:0] a, output logic [15:0] d);
    if (b) begin
      bus_b.addr = a; bus_b.en = 1'b1; bus_b.rd = 1'b1;
    end else begin
      bus_a.addr = a; bus_a.en = 1'b1; bus_a.rd = 1'b1;
    end
    #1;
    d = b ? bus_b.datard : bus_a.datard;
    bus_a.en = 1'b0; bus_a.rd = 1'b0;
    bus_b.en = 1'b0; bus_b.rd = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst = 1'b1;
    pin_a = 32'hFFFF_FFFF;
    pin_b = '0;
    repeat (3) tick();
    n_cmp++; if (pout_a !== 32'h0) begin n_bad++; $display("FAIL reset_pout: got %h want %h", pout_a, 32'h0); end
    n_cmp++; if (poe_a !== 32'h0) begin n_bad++; $display("FAIL reset_poe: got %h want %h", poe_a, 32'h0); end
    n_cmp++; if (ireq_a !== 1'b0) begin n_bad++; $display("FAIL reset_ireq: got %b want 0", ireq_a); end
    n_cmp++; if (poe_b !== 20'h0) begin n_bad++; $display("FAIL reset_poe_b: got %h want %h", poe_b, 20'h0); end
    rst = 1'b0;
    // Select rises on every pin right after release: the pins held high
    // through reset must not be captured.
    bus_write(0, ra(5, 0), 16'hFFFF);
    bus_write(0, ra(5, 1), 16'hFFFF);
    repeat (10) tick();
    bus_read(0, ra(7, 0), d);
    n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL reset_istat_b0: got %h want %h", d, 16'h0); end
    bus_read(0, ra(7, 1), d);
    n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL reset_istat_b1: got %h want %h", d, 16'h0); end
    n_cmp++; if (ireq_a !== 1'b0) begin n_bad++; $display("FAIL reset_ireq_after: got %b want 0", ireq_a); end
    bus_write(0, ra(5, 0), 16'h0);
    bus_write(0, ra(5, 1), 16'h0);
    @(negedge clk);
    pin_a = 32'h0;
    repeat (4) tick();
  endtask

  task automatic test_outputs();
    logic [15:0] d;
    bus_write(0, ra(1, 0), 16'h00FF);
    bus_write(0, ra(0, 0), 16'h1234);
    bus_write(0, ra(2, 0), 16'h0100);
    bus_write(0, ra(3, 0), 16'h0004);
    n_cmp++; if (poe_a !== 32'h0000_00FF) begin n_bad++; $display("FAIL out_poe: got %h want %h", poe_a, 32'h0000_00FF); end
    n_cmp++; if (pout_a !== 32'h0000_1330) begin n_bad++; $display("FAIL out_pout: got %h want %h", pout_a, 32'h0000_1330); end
    bus_read(0, ra(2, 0), d);
    n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL out_read_set: got %h want %h", d, 16'h0); end
    bus_read(0, ra(1, 0), d);
    n_cmp++; if (d !== 16'h00FF) begin n_bad++; $display("FAIL out_read_dir: got %h want %h", d, 16'h00FF); end
    // Strobe qualification: rd without en returns 0.
    bus_a.addr = ra(1, 0); bus_a.rd = 1'b1; bus_a.en = 1'b0;
    #1;
    n_cmp++; if (bus_a.datard !== 16'h0) begin n_bad++; $display("FAIL out_read_no_en: got %h want %h", bus_a.datard, 16'h0); end
    bus_a.rd = 1'b0;
    // Pin change reaches DATA after 2 edges.
    @(negedge clk);
    pin_a = 32'hA5A5_0000;
    tick();
    bus_read(0, ra(0, 1), d);
    n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL data_edge1: got %h want %h", d, 16'h0); end
    tick();
    bus_read(0, ra(0, 1), d);
    n_cmp++; if (d !== 16'hA5A5) begin n_bad++; $display("FAIL data_edge2: got %h want %h", d, 16'hA5A5); end
    @(negedge clk);
    pin_a = 32'h0;
    repeat (4) tick();
  endtask

  task automatic test_rise_irq();
    logic [15:0] d;
    bus_write(0, ra(5, 1), 16'h0001);
    bus_write(0, ra(4, 1), 16'h0001);
    @(negedge clk);
    pin_a[16] = 1'b1;
    tick();
    tick();
    bus_read(0, ra(7, 1), d);
    n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL rise_istat_edge2: got %h want %h", d, 16'h0); end
    tick();
    bus_read(0, ra(7, 1), d);
    n_cmp++; if (d !== 16'h0001) begin n_bad++; $display("FAIL rise_istat_edge3: got %h want %h", d, 16'h0001); end
    n_cmp++; if (ireq_a !== 1'b0) begin n_bad++; $display("FAIL rise_ireq_edge3: got %b want 0", ireq_a); end
    tick();
    n_cmp++; if (ireq_a !== 1'b1) begin n_bad++; $display("FAIL rise_ireq_edge4: got %b want 1", ireq_a); end
    bus_write(0, ra(7, 1), 16'h0001);
    bus_read(0, ra(7, 1), d);
    n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL w1c_istat: got %h want %h", d, 16'h0); end
    n_cmp++; if (ireq_a !== 1'b1) begin n_bad++; $display("FAIL w1c_ireq_same_edge: got %b want 1", ireq_a); end
    tick();
    n_cmp++; if (ireq_a !== 1'b0) begin n_bad++; $display("FAIL w1c_ireq_next_edge: got %b want 0", ireq_a); end
    // Pending status with IEN off, then enabling it raises ireq one edge later.
    bus_write(0, ra(4, 1), 16'h0000);
    @(negedge clk);
    pin_a[16] = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    pin_a[16] = 1'b1;
    repeat (5) tick();
    bus_read(0, ra(7, 1), d);
    n_cmp++; if (d !== 16'h0001) begin n_bad++; $display("FAIL ien_off_istat: got %h want %h", d, 16'h0001); end
    n_cmp++; if (ireq_a !== 1'b0) begin n_bad++; $display("FAIL ien_off_ireq: got %b want 0", ireq_a); end
    bus_write(0, ra(4, 1), 16'h0001);
    n_cmp++; if (ireq_a !== 1'b0) begin n_bad++; $display("FAIL ien_on_same_edge: got %b want 0", ireq_a); end
    tick();
    n_cmp++; if (ireq_a !== 1'b1) begin n_bad++; $display("FAIL ien_on_next_edge: got %b want 1", ireq_a); end
    bus_write(0, ra(7, 1), 16'h0001);
    bus_write(0, ra(4, 1), 16'h0000);
    bus_write(0, ra(5, 1), 16'h0000);
    tick();
  endtask

  task automatic test_both_edges();
    logic [15:0] d;
    bus_write(0, ra(5, 0), 16'h8000);
    bus_write(0, ra(6, 0), 16'h8000);
    @(negedge clk);
    pin_a[15] = 1'b1;
    repeat (3) tick();
    bus_read(0, ra(7, 0), d);
    n_cmp++; if (d !== 16'h8000) begin n_bad++; $display("FAIL both_rise: got %h want %h", d, 16'h8000); end
    bus_write(0, ra(7, 0), 16'h8000);
    bus_read(0, ra(7, 0), d);
    n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL both_cleared: got %h want %h", d, 16'h0); end
    @(negedge clk);
    pin_a[15] = 1'b0;
    repeat (2) tick();
    bus_read(0, ra(7, 0), d);
    n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL both_fall_edge2: got %h want %h", d, 16'h0); end
    tick();
    bus_read(0, ra(7, 0), d);
    n_cmp++; if (d !== 16'h8000) begin n_bad++; $display("FAIL both_fall: got %h want %h", d, 16'h8000); end
    bus_write(0, ra(7, 0), 16'h8000);
    bus_write(0, ra(5, 0), 16'h0);
    bus_write(0, ra(6, 0), 16'h0);
  endtask

  task automatic test_collision();
    logic [15:0] d;
    bus_write(0, ra(6, 0), 16'h0028);
    @(negedge clk);
    pin_a[3] = 1'b1;
    pin_a[5] = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    pin_a[5] = 1'b0;
    repeat (3) tick();
    bus_read(0, ra(7, 0), d);
    n_cmp++; if (d !== 16'h0020) begin n_bad++; $display("FAIL coll_pre: got %h want %h", d, 16'h0020); end
    // Fall on pin 3 is captured on the third edge, the same edge as this W1C.
    @(negedge clk);
    pin_a[3] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    bus_write(0, ra(7, 0), 16'h0028);
    bus_read(0, ra(7, 0), d);
    n_cmp++; if (d !== 16'h0008) begin n_bad++; $display("FAIL coll_set_wins: got %h want %h", d, 16'h0008); end
    bus_write(0, ra(7, 0), 16'h0008);
    bus_read(0, ra(7, 0), d);
    n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL coll_later_clear: got %h want %h", d, 16'h0); end
    bus_write(0, ra(6, 0), 16'h0);
  endtask

  task automatic test_width20();
    logic [15:0] d;
    bus_write(1, ra(1, 1), 16'hFFFF);
    n_cmp++; if (poe_b !== 20'hF_0000) begin n_bad++; $display("FAIL w20_poe: got %h want %h", poe_b, 20'hF_0000); end
    bus_read(1, ra(1, 1), d);
    n_cmp++; if (d !== 16'h000F) begin n_bad++; $display("FAIL w20_read_dir_b1: got %h want %h", d, 16'h000F); end
    bus_write(1, ra(4, 2), 16'hFFFF);
    bus_write(1, ra(1, 3), 16'hFFFF);
    bus_read(1, ra(4, 2), d);
    n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL w20_read_ien_b2: got %h want %h", d, 16'h0); end
    bus_read(1, ra(1, 3), d);
    n_cmp++; if (d !== 16'h0) begin n_bad++; $display("FAIL w20_read_dir_b3: got %h want %h", d, 16'h0); end
    n_cmp++; if (poe_b !== 20'hF_0000) begin n_bad++; $display("FAIL w20_poe_after_b3: got %h want %h", poe_b, 20'hF_0000); end
    bus_write(1, ra(0, 1), 16'hFFFF);
    n_cmp++; if (pout_b !== 20'hF_0000) begin n_bad++; $display("FAIL w20_pout: got %h want %h", pout_b, 20'hF_0000); end
    bus_write(1, ra(3, 1), 16'h0003);
    n_cmp++; if (pout_b !== 20'hC_0000) begin n_bad++; $display("FAIL w20_clr: got %h want %h", pout_b, 20'hC_0000); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (pout_a !== 32'h0) begin n_bad++; $display("FAIL mid_reset_pout: got %h want %h", pout_a, 32'h0); end
    n_cmp++; if (poe_a !== 32'h0) begin n_bad++; $display("FAIL mid_reset_poe: got %h want %h", poe_a, 32'h0); end
    n_cmp++; if (poe_b !== 20'h0) begin n_bad++; $display("FAIL mid_reset_poe_b: got %h want %h", poe_b, 20'h0); end
    n_cmp++; if (pout_b !== 20'h0) begin n_bad++; $display("FAIL mid_reset_pout_b: got %h want %h", pout_b, 20'h0); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus_a.addr = '0; bus_a.datawr = '0; bus_a.en = 1'b0; bus_a.rd = 1'b0; bus_a.wr = 1'b0;
    bus_b.addr = '0; bus_b.datawr = '0; bus_b.en = 1'b0; bus_b.rd = 1'b0; bus_b.wr = 1'b0;
    test_reset();
    test_outputs();
    test_rise_irq();
    test_both_edges();
    test_collision();
    test_width20();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_irq.md
# gpio_irq

Parametrised GPIO block with edge-triggered interrupts, successor to the fixed 32-pin GPIO on the cartridge secondary bus. Provides up to 64 pins in 16-bit banks, with per-pin direction, atomic set/clear of outputs, input synchronisation, rising/falling edge capture into sticky status bits and a registered interrupt request to the primary interface. It sits behind the address decode of a top-level design alongside the SDRAM controller; pad tristating stays in the top level.

## Interface
- WIDTH, 32: number of pins, 1..64; bank count = ceil(WIDTH/16).
- Clk  input  1  system clock; all state on rising edge.
- Reset  input  1  asynchronous, active-high.
- Addr  input  5  {reg[2:0], bank[1:0]}.
- DataWr  input  16  write data.
- DataRd  output  16  read data; combinational from Addr, valid while En & Rd, else 0.
- En  input  1  block select from address decode.
- Rd  input  1  read strobe.
- Wr  input  1  write strobe; one write per Clk cycle with En & Wr high.
- PIn  input  WIDTH  raw pad inputs, asynchronous.
- POut  output  WIDTH  output data register.
- POe  output  WIDTH  output enable (1 = drive).
- IReq  output  1  interrupt request, active-high, registered.

## Operation
- Registers, 16 bits per bank; reg codes:
  - 0 DATA: read returns synchronised pin state; write loads POut.
  - 1 DIR: read/write POe.
  - 2 SET: write-only; POut |= DataWr. Reads return 0.
  - 3 CLR: write-only; POut &= ~DataWr. Reads return 0.
  - 4 IEN: read/write interrupt enable.
  - 5 IRISE: read/write rising-edge select.
  - 6 IFALL: read/write falling-edge select. IRISE and IFALL both set selects both edges.
  - 7 ISTAT: read status; write-1-to-clear. Reads have no side effects.
- Bits at or above WIDTH and banks at or beyond the bank count read 0; writes to them are ignored.
- Input path: 2-flop synchroniser (Sync) followed by a Prev register.
  - rise = Sync & ~Prev; fall = ~Sync & Prev.
  - ISTAT[i] is set on (rise & IRISE) | (fall & IFALL), regardless of IEN.
- Simultaneous edge and W1C on the same bit: set wins. Other bits clear normally.
- Edge qualifier: a 2-bit counter runs after Reset deassertion. Edge capture is suppressed until the counter saturates at 3, so a pin held high through reset raises no spurious rise.
- IReq register <= |(ISTAT & IEN).
- Reset values: POut, POe, IEN, IRISE, IFALL, ISTAT, Sync, Prev, counter all 0; IReq 0. All pins are inputs at reset.

## Timing
- Write takes effect on the Clk edge where En & Wr = 1. POut/POe change visible the same edge.
- Pin change to DATA read: 2 edges.
- Pin edge to ISTAT set: 3 edges. Pin edge to IReq high: 4 edges.
- W1C of the last pending enabled bit: ISTAT clears on edge n, IReq drops on edge n+1.
- IEN write enabling an already-pending bit: IReq rises 1 edge later.
- Reset asserted mid-operation clears all state immediately. Pulses shorter than one Clk period may be missed; this is not an error.

## Structure
- Package gpio_irq_pkg holds:
  - register codes REG_DATA..REG_ISTAT;
  - MAX_WIDTH = 64;
  - bank size 16.
- Sub-module gpio_irq_sync(WIDTH): synchroniser, Prev register, and reset-qualifier counter; outputs Sync, rise, fall, qualified.
- Top of block holds the register file, read mux and IReq.

## Test plan
- Reset with PIn = 0xFFFF_FFFF: POut = POe = 0, IReq = 0. No ISTAT bits set in the 10 cycles after release.
- Write DIR bank0 = 0x00FF and DATA = 0x1234, then SET 0x0100 and CLR 0x0004:
  - POe[15:0] = 0x00FF; POut[15:0] = 0x1330.
  - Read SET returns 0.
- IRISE bank1 = 0x0001, IEN bank1 = 0x0001, drive PIn[16] 0->1: ISTAT bank1 = 0x0001 at edge 3, IReq = 1 at edge 4. W1C 0x0001 then IReq = 0 one edge later.
- IRISE = IFALL = 0x8000 on bank0 with a pulse on PIn[15]: status set on the rising edge. After W1C, the falling edge sets it again.
- Edge on PIn[3] arriving in the same cycle as W1C of ISTAT bit 3 (IFALL bit 3 set): ISTAT[3] remains 1.
- WIDTH = 20: bank1 bits 4..15 and banks 2/3 read 0; writing DIR bank1 = 0xFFFF yields POe = 0xF_0000.
